mdu_ctrl: RTL
=============

# mdu_ctrl

Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core, sitting beside the ALU in the E stage. It accepts one mult/div/mthi/mtlo operation per start pulse. It models multi-cycle latency with a busy flag so the hazard unit can stall HI/LO readers, and it generalises operand width and per-class latencies.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width.
- `MULT_CYCLES`, 5, busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, 10, busy cycles for div/divu (≥1).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: launch the operation in `op`. Sampled only when `busy` = 0.
- `op` in 4: operation code from `mdu_pkg`.
- `rs_val` in WIDTH: operand A, or the source value for mthi/mtlo.
- `rt_val` in WIDTH: operand B.
- `busy` out 1: an operation is in flight.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- State machine has two states.
  - IDLE: `busy` = 0.
  - RUN: `busy` = 1; a down-counter of width $clog2(max(MULT_CYCLES, DIV_CYCLES)+1) is running.
- IDLE, `start`, op MULT/MULTU → load the counter with MULT_CYCLES, capture the result into pending registers, go to RUN.
- IDLE, `start`, op DIV/DIVU → the same with DIV_CYCLES.
- IDLE, `start`, op MTHI/MTLO → write `rs_val` to HI or LO at that edge; stay in IDLE; `busy` stays 0.
- RUN → counter decrements each edge. When it reaches 1: HI/LO take the pending result on that edge and the state returns to IDLE.
- `start` while `busy` = 1 is ignored. The pipeline must hold the instruction; this block does not queue it.
- Undefined or NOP op with `start` in IDLE → no state change.
- Arithmetic:
  - MULT: signed WIDTH×WIDTH → 2·WIDTH product; HI = upper half, LO = lower half.
  - MULTU: the same, unsigned.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - DIVU: unsigned.
- Divide by zero, both signed and unsigned: LO = all ones, HI = `rs_val`.
- Signed overflow (most-negative ÷ −1): LO = most negative value, HI = 0.
- Result may be computed at launch or iteratively. HI/LO must change only at the completion edge.

## Timing
- Reset values: `busy` = 0, `hi` = 0, `lo` = 0, state = IDLE, counter = 0. Applies immediately on `reset_n` low, independent of `clk`.
- `start` accepted at edge k with latency N:
  - `busy` is high during cycles k+1 … k+N.
  - HI/LO update at edge k+N.
  - `busy` is low in cycle k+N+1.
  - A new `start` may be accepted at edge k+N+1 at the earliest.
- MTHI/MTLO: HI/LO visible in the cycle after the accepting edge; zero busy cycles.
- Reset mid-RUN aborts the operation. The pending result is discarded and HI/LO are cleared.
- Back-to-back MTHI then MTLO on consecutive edges: both take effect.
- `hi`/`lo`/`busy` are register outputs with no combinational path from inputs.

## Configuration
- `MDU_MADD_EN` defined: adds MADD, MADDU, MSUB, MSUBU.
  - Each uses MULT_CYCLES latency.
  - Result is {HI,LO} ± product (signed or unsigned), with 2·WIDTH wrap-around.
  - The accumulate uses the HI/LO value at the launch edge.
- `MDU_MADD_EN` undefined: those op codes are treated as undefined (no effect), and the accumulator adder is not built.

## Structure
- `mdu_pkg` holds:
  - the 4-bit op enum: NOP=0, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU;
  - the state enum IDLE/RUN.
- The decoder maps instruction funct codes to this enum; this block does not decode instructions.
- One sub-module, `mdu_divider`, is natural. It is a combinational or iterative signed/unsigned divider, including the zero and overflow rules.
- Multiplication stays inline.

## Test plan
- Reset: assert `reset_n` = 0 mid-clock → `busy` = 0, `hi` = `lo` = 0 immediately. Repeat during RUN of a DIV → result is never written.
- MULT, rs = 0xFFFFFFFE (−2), rt = 3 → after 5 busy cycles HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MULTU with the same operands → HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV, rs = −7, rt = 2 → 10 busy cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU, rs = 7, rt = 0 → LO = 0xFFFFFFFF, HI = 7.
- DIV, rs = 0x80000000, rt = 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- `start` of MTLO (rs = 0x1234) in the 3rd busy cycle of a MULT → ignored; the MULT result lands on schedule. MTHI 0xABCD while idle → HI = 0xABCD next cycle, `busy` never rises.
- With `MDU_MADD_EN`: HI:LO = 0:0xFFFFFFFF, then MADDU rs = 1, rt = 1 → HI = 1, LO = 0. Without the macro → HI/LO unchanged and `busy` stays 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op codes and FSM states for the multiply/divide unit.
// Op codes come pre-decoded from the instruction decoder.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mdu_divider.sv
// Combinational signed/unsigned divider with MIPS divide-by-zero and overflow results.
// Zero latency; no flow control (pure function of its inputs).
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONE = '1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;

  always_comb begin
    a_neg  = is_signed & dividend[WIDTH-1];
    b_neg  = is_signed & divisor[WIDTH-1];
    a_mag  = a_neg ? ('0 - dividend) : dividend;
    b_mag  = b_neg ? ('0 - divisor) : divisor;
    // Keep the core divide well-defined; the zero case is overridden below.
    b_safe = (b_mag == '0) ? ONE : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;

    quot = (a_neg ^ b_neg) ? ('0 - q_mag) : q_mag;
    rem  = a_neg ? ('0 - r_mag) : r_mag;

    if (divisor == '0) begin
      quot = ALL_ONE;
      rem  = dividend;
    end else if (is_signed && dividend == MOST_NEG && divisor == ALL_ONE) begin
      quot = MOST_NEG;
      rem  = '0;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MIPS mult/div unit with HI/LO; result computed at launch, committed after MULT_CYCLES/DIV_CYCLES.
// busy stalls HI/LO readers; start while busy is dropped. MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_nxt;
  logic [2*WIDTH-1:0] pend;
  logic [2*WIDTH-1:0] pend_nxt;
  logic [WIDTH-1:0]   hi_nxt;
  logic [WIDTH-1:0]   lo_nxt;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [WIDTH-1:0]   div_quot;
  logic [WIDTH-1:0]   div_rem;

  // Low 2W bits of the extended operands' product equal the true 2W-bit product.
  assign prod_s = {{WIDTH{rs_val[WIDTH-1]}}, rs_val} * {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
  assign prod_u = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};

  mdu_divider #(.WIDTH(WIDTH)) u_divider (
    .dividend  (rs_val),
    .divisor   (rt_val),
    .is_signed (op == OP_DIV),
    .quot      (div_quot),
    .rem       (div_rem)
  );

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] hilo;
  assign hilo = {hi, lo};
`endif

  assign busy = (state == RUN);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    hi_nxt    = hi;
    lo_nxt    = lo;

    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              pend_nxt  = prod_s;
              cnt_nxt   = CW'(MULT_CYCLES);
              state_nxt = RUN;
            end
            OP_MULTU: begin
              pend_nxt  = prod_u;
              cnt_nxt   = CW'(MULT_CYCLES);
              state_nxt = RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_nxt  = {div_rem, div_quot};
              cnt_nxt   = CW'(DIV_CYCLES);
              state_nxt = RUN;
            end
            OP_MTHI: hi_nxt = rs_val;
            OP_MTLO: lo_nxt = rs_val;
`ifdef MDU_MADD_EN
            OP_MADD: begin
              pend_nxt  = hilo + prod_s;
              cnt_nxt   = CW'(MULT_CYCLES);
              state_nxt = RUN;
            end
            OP_MADDU: begin
              pend_nxt  = hilo + prod_u;
              cnt_nxt   = CW'(MULT_CYCLES);
              state_nxt = RUN;
            end
            OP_MSUB: begin
              pend_nxt  = hilo - prod_s;
              cnt_nxt   = CW'(MULT_CYCLES);
              state_nxt = RUN;
            end
            OP_MSUBU: begin
              pend_nxt  = hilo - prod_u;
              cnt_nxt   = CW'(MULT_CYCLES);
              state_nxt = RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          hi_nxt    = pend[2*WIDTH-1:WIDTH];
          lo_nxt    = pend[WIDTH-1:0];
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

endmodule
